// File: rtl/dst_reg_scoreboard_if.sv
// Decode-side bundle for dst_reg_scoreboard: write/issue request, source
// registers, pipeline controls, and the tracked stage state it reports back.
interface dst_reg_scoreboard_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 2
);
  logic [REG_W-1:0] wr_reg;
  logic             wr_en;
  logic             issue;
  logic             freeze;
  logic             flush;
  logic [REG_W-1:0] rs_a;
  logic             rs_a_used;
  logic [REG_W-1:0] rs_b;
  logic             rs_b_used;
  logic             hazard;
  logic             issue_ok;
  logic [REG_W-1:0] ex_reg;
  logic [REG_W-1:0] mem_reg;
  logic [REG_W-1:0] wb_reg;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic [CNT_W-1:0] pending;

  modport master (
    output wr_reg, wr_en, issue, freeze, flush, rs_a, rs_a_used, rs_b, rs_b_used,
    input  hazard, issue_ok, ex_reg, mem_reg, wb_reg,
           ex_valid, mem_valid, wb_valid, pending
  );

  modport slave (
    input  wr_reg, wr_en, issue, freeze, flush, rs_a, rs_a_used, rs_b, rs_b_used,
    output hazard, issue_ok, ex_reg, mem_reg, wb_reg,
           ex_valid, mem_valid, wb_valid, pending
  );
endinterface

// File: rtl/dst_reg_scoreboard.sv
// Destination-register scoreboard for EX/MEM/WB with RAW hazard detection and
// internal issue gating. Define WB_BYPASS_EN to exclude WB from hazard matching.
module dst_reg_scoreboard #(
  parameter int REG_W = 3,
  parameter int CNT_W = 2
) (
  input logic                clk,
  input logic                rst,
  dst_reg_scoreboard_if.slave bus
);

  logic             ex_valid, mem_valid, wb_valid;
  logic [REG_W-1:0] ex_reg, mem_reg, wb_reg;
  logic [CNT_W-1:0] pending;

  logic             ex_valid_n, mem_valid_n, wb_valid_n;
  logic [REG_W-1:0] ex_reg_n, mem_reg_n, wb_reg_n;
  logic [CNT_W-1:0] pending_n;

  logic hit_a, hit_b, hazard, issue_ok;

  // Only current stage contents are compared; the decode wr_reg never is.
  always_comb begin
    hit_a = (ex_valid && (ex_reg == bus.rs_a)) || (mem_valid && (mem_reg == bus.rs_a));
    hit_b = (ex_valid && (ex_reg == bus.rs_b)) || (mem_valid && (mem_reg == bus.rs_b));
`ifdef WB_BYPASS_EN
`else
    hit_a = hit_a || (wb_valid && (wb_reg == bus.rs_a));
    hit_b = hit_b || (wb_valid && (wb_reg == bus.rs_b));
`endif
  end

  assign hazard   = (bus.rs_a_used && hit_a) || (bus.rs_b_used && hit_b);
  assign issue_ok = bus.issue && !hazard && !bus.freeze;

  always_comb begin
    ex_valid_n  = ex_valid;
    ex_reg_n    = ex_reg;
    mem_valid_n = mem_valid;
    mem_reg_n   = mem_reg;
    wb_valid_n  = wb_valid;
    wb_reg_n    = wb_reg;
    if (!bus.freeze) begin
      wb_valid_n  = mem_valid;
      wb_reg_n    = mem_reg;
      mem_valid_n = ex_valid;
      mem_reg_n   = ex_reg;
      if (issue_ok && bus.wr_en) begin
        ex_valid_n = 1'b1;
        ex_reg_n   = bus.wr_reg;
      end else begin
        ex_valid_n = 1'b0;
        ex_reg_n   = '0;
      end
    end
    // Flush kills only the EX entry; the older entry leaving EX has already moved on.
    if (bus.flush) begin
      ex_valid_n = 1'b0;
      ex_reg_n   = '0;
    end
    pending_n = CNT_W'(ex_valid_n) + CNT_W'(mem_valid_n) + CNT_W'(wb_valid_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
      ex_reg    <= '0;
      mem_reg   <= '0;
      wb_reg    <= '0;
      pending   <= '0;
    end else begin
      ex_valid  <= ex_valid_n;
      mem_valid <= mem_valid_n;
      wb_valid  <= wb_valid_n;
      ex_reg    <= ex_reg_n;
      mem_reg   <= mem_reg_n;
      wb_reg    <= wb_reg_n;
      pending   <= pending_n;
    end
  end

  assign bus.hazard    = hazard;
  assign bus.issue_ok  = issue_ok;
  assign bus.ex_reg    = ex_reg;
  assign bus.mem_reg   = mem_reg;
  assign bus.wb_reg    = wb_reg;
  assign bus.ex_valid  = ex_valid;
  assign bus.mem_valid = mem_valid;
  assign bus.wb_valid  = wb_valid;
  assign bus.pending   = pending;

endmodule

// File: tb/tb_dst_reg_scoreboard.sv
// Directed self-checking bench for dst_reg_scoreboard; stage state is compared
// as one packed snapshot {ex_v,ex_r,mem_v,mem_r,wb_v,wb_r,pending}.
module tb_dst_reg_scoreboard;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dst_reg_scoreboard_if #(.REG_W(3), .CNT_W(2)) bus ();

  dst_reg_scoreboard #(.REG_W(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [13:0] snap;
  assign snap = {bus.ex_valid, bus.ex_reg, bus.mem_valid, bus.mem_reg,
                 bus.wb_valid, bus.wb_reg, bus.pending};

`ifdef WB_BYPASS_EN
  localparam int STALL_CYCLES = 2;
`else
  localparam int STALL_CYCLES = 3;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_reg    = '0;
    bus.wr_en     = 1'b0;
    bus.issue     = 1'b0;
    bus.freeze    = 1'b0;
    bus.flush     = 1'b0;
    bus.rs_a      = '0;
    bus.rs_a_used = 1'b0;
    bus.rs_b      = '0;
    bus.rs_b_used = 1'b0;
  endtask

  task automatic push(input logic [2:0] r);
    bus.wr_reg = r;
    bus.wr_en  = 1'b1;
    bus.issue  = 1'b1;
    tick();
    bus.wr_en  = 1'b0;
    bus.issue  = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.issue = 1'b1;
    bus.wr_reg = 3'd5;
    bus.rs_a = 3'd5;
    bus.rs_a_used = 1'b1;
    tick();
    tick();
    total++;
    if (snap !== 14'h0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %h want %h", snap, 14'h0);
    end
    total++;
    if (bus.hazard !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_hazard: got %b want 0", bus.hazard);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_propagation();
    logic [13:0] exp [4];
    exp[0] = {1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0, 2'd1};
    exp[1] = {1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 2'd1};
    exp[2] = {1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 2'd1};
    exp[3] = 14'h0;
    push(3'd5);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (snap !== exp[i]) begin
        bad++;
        $display("[TB] FAIL propagate_%0d: got %h want %h", i, snap, exp[i]);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_raw_stall();
    push(3'd3);
    bus.rs_a = 3'd3;
    bus.rs_a_used = 1'b1;
    bus.wr_reg = 3'd4;
    bus.wr_en = 1'b1;
    bus.issue = 1'b1;
    #1;
    total++;
    if (bus.issue_ok !== 1'b0) begin
      bad++;
      $display("[TB] FAIL raw_issue_ok: got %b want 0", bus.issue_ok);
    end
    for (int i = 0; i < STALL_CYCLES; i++) begin
      total++;
      if (bus.hazard !== 1'b1) begin
        bad++;
        $display("[TB] FAIL raw_hazard_%0d: got %b want 1", i, bus.hazard);
      end
      tick();
      total++;
      if (bus.ex_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL raw_bubble_%0d: got %b want 0", i, bus.ex_valid);
      end
    end
    total++;
    if ({bus.hazard, bus.issue_ok} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL raw_release: got %b want 01", {bus.hazard, bus.issue_ok});
    end
    tick();
    total++;
    if ({bus.ex_valid, bus.ex_reg, bus.pending} !== {1'b1, 3'd4, 2'd1}) begin
      bad++;
      $display("[TB] FAIL raw_issue: got %h want %h",
               {bus.ex_valid, bus.ex_reg, bus.pending}, {1'b1, 3'd4, 2'd1});
    end
    drain();
  endtask

  task automatic test_freeze();
    logic [13:0] full;
    full = {1'b1, 3'd4, 1'b1, 3'd2, 1'b1, 3'd1, 2'd3};
    push(3'd1);
    push(3'd2);
    push(3'd4);
    bus.freeze = 1'b1;
    bus.issue = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_reg = 3'd7;
    #1;
    total++;
    if (bus.issue_ok !== 1'b0) begin
      bad++;
      $display("[TB] FAIL freeze_issue_ok: got %b want 0", bus.issue_ok);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (snap !== full) begin
        bad++;
        $display("[TB] FAIL freeze_hold_%0d: got %h want %h", i, snap, full);
      end
    end
    idle();
    tick();
    total++;
    if (snap !== {1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd2, 2'd2}) begin
      bad++;
      $display("[TB] FAIL freeze_release: got %h want %h", snap,
               {1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd2, 2'd2});
    end
    drain();
  endtask

  task automatic test_flush();
    push(3'd2);
    push(3'd6);
    bus.flush = 1'b1;
    tick();
    total++;
    if (snap !== {1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 3'd2, 2'd2}) begin
      bad++;
      $display("[TB] FAIL flush_shift: got %h want %h", snap,
               {1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 3'd2, 2'd2});
    end
    drain();
    push(3'd2);
    push(3'd6);
    bus.flush = 1'b1;
    bus.freeze = 1'b1;
    bus.issue = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_reg = 3'd5;
    tick();
    total++;
    if (snap !== {1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 2'd1}) begin
      bad++;
      $display("[TB] FAIL flush_frozen: got %h want %h", snap,
               {1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 2'd1});
    end
    drain();
  endtask

  task automatic test_unused_source();
    push(3'd7);
    bus.rs_b = 3'd7;
    bus.rs_b_used = 1'b0;
    bus.rs_a = 3'd0;
    bus.rs_a_used = 1'b1;
    bus.wr_reg = 3'd1;
    bus.wr_en = 1'b1;
    bus.issue = 1'b1;
    #1;
    total++;
    if ({bus.hazard, bus.issue_ok} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL unused_src: got %b want 01", {bus.hazard, bus.issue_ok});
    end
    tick();
    total++;
    if (snap !== {1'b1, 3'd1, 1'b1, 3'd7, 1'b0, 3'd0, 2'd2}) begin
      bad++;
      $display("[TB] FAIL unused_issue: got %h want %h", snap,
               {1'b1, 3'd1, 1'b1, 3'd7, 1'b0, 3'd0, 2'd2});
    end
    bus.wr_en = 1'b0;
    bus.issue = 1'b0;
    bus.rs_a_used = 1'b0;
    bus.rs_b_used = 1'b1;
    #1;
    total++;
    if (bus.hazard !== 1'b1) begin
      bad++;
      $display("[TB] FAIL used_src_b_mem: got %b want 1", bus.hazard);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    push(3'd3);
    push(3'd3);
    push(3'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rs_a = 3'd3;
    bus.rs_a_used = 1'b1;
    bus.rs_b = 3'd6;
    bus.rs_b_used = 1'b1;
    #1;
    total++;
    if ({snap, bus.hazard} !== 15'h0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got %h want %h", {snap, bus.hazard}, 15'h0);
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    idle();
    test_reset();
    test_propagation();
    test_raw_stall();
    test_freeze();
    test_flush();
    test_unused_source();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
